alu_result_checker: RTL

Synthesizable self-checking monitor on the response side of the sequential ALU. It samples the same operand1/operand2/opcode stream that drives the ALU and computes the expected result with a reference model. It delays that expectation to match the ALU latency, compares it with the ALU `out` port, and keeps check and error counters plus first-failure capture. It sits beside the ALU in the testbench and can also be used on FPGA as a built-in self-check.

---
 rtl/alu_result_checker.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// Self-check monitor for the sequential ALU: reference result delayed LATENCY edges, compared against out; no backpressure.
// First-failure capture registers exist only when ALU_CHK_CAPTURE_EN is defined; otherwise first_* read 0.
module alu_result_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       operand1,
    input  logic [7:0]       operand2,
    input  logic [2:0]       opcode,
    input  logic [7:0]       out,
    output logic             mismatch,
    output logic             err_flag,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       first_exp,
    output logic [7:0]       first_act,
    output logic [2:0]       first_op
);

    localparam int LAST = LATENCY - 1;

    logic [7:0] w_ref;
    logic       w_ref_chk;
    logic       w_cmp;
    logic       w_bad;

    logic       r_vld [LATENCY];
    logic       r_chk [LATENCY];
    logic [7:0] r_exp [LATENCY];

    // The low byte of a two's complement product does not depend on signedness.
    always_comb begin
        w_ref     = 8'h00;
        w_ref_chk = 1'b1;
        case (opcode)
            3'd0:    w_ref = operand1 + operand2;
            3'd1:    w_ref = operand1 - operand2;
            3'd2:    w_ref = operand1 * operand2;
            3'd3:    w_ref = operand1 & operand2;
            3'd4:    w_ref = operand1 | operand2;
            3'd5:    w_ref = operand1 ^ operand2;
            default: w_ref_chk = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_vld[i] <= 1'b0;
        end else begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_chk[0] <= w_ref_chk;
        r_exp[0] <= w_ref;
        for (int i = 1; i < LATENCY; i++) begin
            r_chk[i] <= r_chk[i-1];
            r_exp[i] <= r_exp[i-1];
        end
    end

    assign w_cmp = r_vld[LAST] && r_chk[LAST];
    assign w_bad = w_cmp && (out != r_exp[LAST]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_flag  <= 1'b0;
            check_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            mismatch <= w_bad;
            if (w_bad) err_flag <= 1'b1;
            if (w_cmp && (check_cnt != '1)) check_cnt <= check_cnt + CNT_W'(1);
            if (w_bad && (err_cnt != '1))   err_cnt   <= err_cnt + CNT_W'(1);
        end
    end

`ifdef ALU_CHK_CAPTURE_EN
    logic [2:0] r_op [LATENCY];
    logic [7:0] r_first_exp;
    logic [7:0] r_first_act;
    logic [2:0] r_first_op;

    always_ff @(posedge clk) begin
        r_op[0] <= opcode;
        for (int i = 1; i < LATENCY; i++) r_op[i] <= r_op[i-1];
    end

    // Load only on the miscompare that raises err_flag, then hold until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_exp <= 8'h00;
            r_first_act <= 8'h00;
            r_first_op  <= 3'd0;
        end else if (w_bad && !err_flag) begin
            r_first_exp <= r_exp[LAST];
            r_first_act <= out;
            r_first_op  <= r_op[LAST];
        end
    end

    assign first_exp = r_first_exp;
    assign first_act = r_first_act;
    assign first_op  = r_first_op;
`else
    assign first_exp = 8'h00;
    assign first_act = 8'h00;
    assign first_op  = 3'd0;
`endif

endmodule
